// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: tracks pending writes, gates issue on RAW/WAW/capacity hazards
// and sequences a RUN/DRAIN/DRAINED pipeline drain. Optional stall counter: ID_SCOREBOARD_STALL_CNT_EN.
module id_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic [4:0]  id_rw,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_writes,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic        drain_req,
  output logic        issue,
  output logic        stall,
  output logic [31:0] busy,
  output logic [2:0]  inflight,
  output logic        drained,
  output logic        wb_err,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_busy;
  logic [2:0]  r_inflight;
  logic        r_wb_err;
  logic        r_drained;

  logic        w_hazard;
  logic        w_set;
  logic        w_retire;
  logic        w_bad_wb;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // Hazards look only at the registered scoreboard; a write-back in the same cycle is not bypassed.
  assign w_hazard = (id_uses_ra & r_busy[id_ra])
                  | (id_uses_rb & r_busy[id_rb])
                  | (id_writes  & r_busy[id_rw])
                  | (id_writes  & (r_inflight == MAX_CNT));

  assign issue = id_valid & ~w_hazard & ex_ready & ~flush & (r_state == RUN);
  assign stall = id_valid & ~issue;

  assign w_set      = issue & id_writes;
  assign w_retire   = wb_we & r_busy[wb_rw];
  assign w_bad_wb   = wb_we & ~r_busy[wb_rw];
  assign w_set_mask = w_set    ? (32'd1 << id_rw) : 32'd0;
  assign w_clr_mask = w_retire ? (32'd1 << wb_rw) : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= 32'd0;
      r_inflight <= 3'd0;
      r_wb_err   <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      if (w_set && !w_retire && r_inflight != MAX_CNT)
        r_inflight <= r_inflight + 3'd1;
      else if (w_retire && !w_set && r_inflight != 3'd0)
        r_inflight <= r_inflight - 3'd1;
      if (w_bad_wb)
        r_wb_err <= 1'b1;
    end
  end

  // Drain sequencer; drained is registered alongside the state so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (drain_req) r_state <= DRAIN;
          r_drained <= 1'b0;
        end
        DRAIN: begin
          if (!drain_req) begin
            r_state   <= RUN;
            r_drained <= 1'b0;
          end else if (r_inflight == 3'd0) begin
            r_state   <= DRAINED;
            r_drained <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            r_state   <= RUN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef ID_SCOREBOARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cnt <= 16'd0;
    else if (stall && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

  assign busy     = r_busy;
  assign inflight = r_inflight;
  assign drained  = r_drained;
  assign wb_err   = r_wb_err;

endmodule
